pmod_loopback_tester: RTL
=========================

// Module: pmod_loopback_tester
// PURPOSE
//  Clocked, parametrised successor of the 2-bit PMOD IO loopback check. Drives a
//  WIDTH-bit pattern out of one inout bank and samples it back on the other
//  (JC<->JD jumpers), then compares and reports pass/fail, an error count and a
//  one-hot LED view. Sits between board switches/buttons and the PMOD pins.
// PARAMETERS
//  WIDTH          2   bits per PMOD bank; legal range 1..4 (LED bus is 2**WIDTH wide)
//  SETTLE_CYCLES  4   cycles the pattern is held before sampling; must be >= 2
//  CNT_W          8   width of the saturating mismatch counter
// PORTS
//  clk      in     1          system clock (clk_out1 of the clock wizard)
//  rst_n    in     1          asynchronous, active-low reset
//  wr_data  in     WIDTH      test pattern from switches
//  wr_en    in     1          load wr_data into pat_reg (accepted in IDLE only)
//  sel      in     1          0: drive out1, read out2; 1: drive out2, read out1
//  start    in     1          begin a test (accepted in IDLE only, level or pulse)
//  rd_en    in     1          1: show captured value on led; 0: led all zero
//  clr_err  in     1          synchronous clear of err_cnt
//  out1     inout  WIDTH      PMOD bank 1
//  out2     inout  WIDTH      PMOD bank 2
//  busy     out    1          high from the cycle after start until done
//  done     out    1          one-cycle pulse when a test finishes
//  pass     out    1          result of the last test; held until the next
//  err_cnt  out    CNT_W      saturating count of mismatching checks
//  rd_val   out    WIDTH      last captured loopback value
//  led      out    2**WIDTH   one-hot decode of rd_val, gated by rd_en
// BEHAVIOUR
//  - Reset (async): state IDLE; pat_reg, rd_val, err_cnt, pass, busy and done = 0;
//    led = 0; out1 and out2 hi-Z immediately. Releases cleanly mid-test.
//  - Read path: each bank's input goes through a 2-flop synchroniser. Only the
//    synchronised value is ever compared.
//  - FSM: IDLE -> DRIVE (1 cycle) -> SETTLE (SETTLE_CYCLES cycles) -> CHECK (1)
//    -> IDLE.
//  - IDLE: both banks hi-Z. wr_en loads pat_reg. start latches sel into dir.
//  - DRIVE/SETTLE: the dir bank drives pat_reg; the other bank stays hi-Z.
//  - CHECK: rd_val <= synchronised read bank; pass <= (read == pat_reg).
//    On mismatch, err_cnt increments and saturates at all-ones. done pulses.
//    The driver releases on the IDLE transition.
//  - Latency: start sampled at edge N -> done high at edge N+SETTLE_CYCLES+2.
//  - While busy: start, wr_en and sel changes are ignored (dir and pat_reg frozen).
//  - clr_err in the same cycle as a mismatch increment: clear wins (err_cnt = 0).
//  - led[i] = rd_en & (rd_val == i). Combinational on registered values.
//  - A driven bank is never driven in IDLE. The two banks are never driven in the
//    same cycle.
// CONFIGURATION
//  LOOPBACK_SWEEP_EN undefined: start runs a single pattern (pat_reg) in a single
//    direction (sel), as above.
//  LOOPBACK_SWEEP_EN defined: start ignores pat_reg and sel.
//    - Runs patterns 0..2**WIDTH-1 with dir=0, then one TURN cycle (both hi-Z),
//      then the same patterns with dir=1.
//    - Each pattern takes DRIVE+SETTLE+CHECK. Consecutive patterns chain with no
//      IDLE in between.
//    - err_cnt counts every mismatching check. rd_val holds the last capture.
//    - pass = 1 only if all 2**(WIDTH+1) checks match.
//    - done pulses once, 2**(WIDTH+1)*(SETTLE_CYCLES+2)+1 cycles after start.
// TESTING (WIDTH=2, SETTLE_CYCLES=4, bench wires out1<->out2 unless stated)
//  1 rst_n=0 mid-SETTLE -> out1/out2 = Z at once; busy=0, done=0, err_cnt=0,
//    led=0; after release, FSM is in IDLE.
//  2 wr_en with wr_data=2'b10, sel=0, start at edge N -> out1 driven 2'b10;
//    done at N+6; pass=1; rd_val=2; led=4'b0100 when rd_en=1, 4'b0000 when rd_en=0.
//  3 Bench forces out2[0]=0, pattern 2'b11, sel=0 -> pass=0, rd_val=2'b10,
//    err_cnt 0->1.
//  4 CNT_W=2 with 4 failing runs -> err_cnt=3 (saturated); clr_err asserted on
//    the CHECK cycle of a failing run -> err_cnt=0.
//  5 start at N, then sel toggled and start/wr_en pulsed at N+2 -> same bank stays
//    driven; pat_reg unchanged; exactly one done at N+6.
//  6 LOOPBACK_SWEEP_EN, clean loop -> 8 checks, done at start+49, pass=1,
//    err_cnt=0, rd_val=3; with out1[1] stuck 0 -> pass=0, err_cnt=4.

Source files
------------

// File: rtl/pmod_loopback_tester_if.sv
// pmod_loopback_tester_if: control/status bundle between the board
// switches/buttons side and the PMOD loopback tester.
interface pmod_loopback_tester_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0]      wr_data;
    logic                  wr_en;
    logic                  sel;
    logic                  start;
    logic                  rd_en;
    logic                  clr_err;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [CNT_W-1:0]      err_cnt;
    logic [WIDTH-1:0]      rd_val;
    logic [(2**WIDTH)-1:0] led;

    modport master (
        output wr_data, wr_en, sel, start, rd_en, clr_err,
        input  busy, done, pass, err_cnt, rd_val, led
    );

    modport slave (
        input  wr_data, wr_en, sel, start, rd_en, clr_err,
        output busy, done, pass, err_cnt, rd_val, led
    );
endinterface

// File: rtl/pmod_loopback_tester.sv
// pmod_loopback_tester: drives a test pattern out of one PMOD bank, samples the
// jumpered bank back through a 2-flop synchroniser and reports pass/fail, a
// saturating mismatch count and a one-hot LED view of the captured value.
// Build option: LOOPBACK_SWEEP_EN sweeps every pattern in both directions.
module pmod_loopback_tester #(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pmod_loopback_tester_if.slave bus,
    inout  wire [WIDTH-1:0]       out1,
    inout  wire [WIDTH-1:0]       out2
);
    localparam int unsigned SCNT_W = $clog2(SETTLE_CYCLES);
    localparam int unsigned LEDS   = 2**WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_TURN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SCNT_W-1:0]   r_settle_cnt;
    logic                r_dir;
    logic [WIDTH-1:0]    r_pat_reg;
    logic [WIDTH-1:0]    r_sync1_1, r_sync2_1;
    logic [WIDTH-1:0]    r_sync1_2, r_sync2_2;
    logic [WIDTH-1:0]    r_rd_val;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_pass;
    logic                r_done;
    logic                w_drive_en;
    logic                w_match;
    logic [WIDTH-1:0]    w_pat_out;
    logic [WIDTH-1:0]    w_rd_sync;
    logic [LEDS-1:0]     w_led;
`ifdef LOOPBACK_SWEEP_EN
    logic [WIDTH-1:0]    r_sweep_pat;
    logic                r_all_ok;
    logic                w_pat_last;
    logic                w_last;

    assign w_pat_last = (r_sweep_pat == '1);
    assign w_last     = w_pat_last && r_dir;
    assign w_pat_out  = r_sweep_pat;
`else
    assign w_pat_out  = r_pat_reg;
`endif

    // Driver stays on through CHECK so chained sweep patterns never release.
    assign w_drive_en = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) ||
                        (r_state == ST_CHECK);
    assign out1       = (w_drive_en && !r_dir) ? w_pat_out : 'z;
    assign out2       = (w_drive_en &&  r_dir) ? w_pat_out : 'z;

    assign w_rd_sync  = r_dir ? r_sync2_1 : r_sync2_2;
    assign w_match    = (w_rd_sync == w_pat_out);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = ST_DRIVE;
            ST_DRIVE:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == SCNT_W'(SETTLE_CYCLES - 1)) w_state_nxt = ST_CHECK;
`ifdef LOOPBACK_SWEEP_EN
            ST_CHECK: begin
                if (!w_pat_last) w_state_nxt = ST_DRIVE;
                else if (!r_dir) w_state_nxt = ST_TURN;
                else             w_state_nxt = ST_IDLE;
            end
`else
            ST_CHECK:  w_state_nxt = ST_IDLE;
`endif
            ST_TURN:   w_state_nxt = ST_DRIVE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Settle timer, counts only while in SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_settle_cnt <= '0;
        else if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + SCNT_W'(1);
        else                           r_settle_cnt <= '0;
    end

    // Pattern and direction capture; frozen outside IDLE (sweep steps its own counter).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat_reg   <= '0;
            r_dir       <= 1'b0;
`ifdef LOOPBACK_SWEEP_EN
            r_sweep_pat <= '0;
`endif
        end else if (r_state == ST_IDLE) begin
            if (bus.wr_en) r_pat_reg <= bus.wr_data;
`ifdef LOOPBACK_SWEEP_EN
            if (bus.start) begin
                r_dir       <= 1'b0;
                r_sweep_pat <= '0;
            end
        end else if (r_state == ST_CHECK) begin
            r_sweep_pat <= r_sweep_pat + WIDTH'(1);
            if (w_pat_last) r_dir <= 1'b1;
`else
            if (bus.start) r_dir <= bus.sel;
`endif
        end
    end

    // Two-flop synchronisers on both banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1_1 <= '0;
            r_sync2_1 <= '0;
            r_sync1_2 <= '0;
            r_sync2_2 <= '0;
        end else begin
            r_sync1_1 <= out1;
            r_sync2_1 <= r_sync1_1;
            r_sync1_2 <= out2;
            r_sync2_2 <= r_sync1_2;
        end
    end

    // Result capture and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_val <= '0;
            r_pass   <= 1'b0;
            r_done   <= 1'b0;
`ifdef LOOPBACK_SWEEP_EN
            r_all_ok <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_CHECK) begin
                r_rd_val <= w_rd_sync;
`ifdef LOOPBACK_SWEEP_EN
                r_all_ok <= r_all_ok & w_match;
                if (w_last) begin
                    r_pass <= r_all_ok & w_match;
                    r_done <= 1'b1;
                end
            end else if ((r_state == ST_IDLE) && bus.start) begin
                r_all_ok <= 1'b1;
`else
                r_pass   <= w_match;
                r_done   <= 1'b1;
`endif
            end
        end
    end

    // Saturating mismatch counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= '0;
        else if (bus.clr_err)
            r_err_cnt <= '0;
        else if ((r_state == ST_CHECK) && !w_match && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + CNT_W'(1);
    end

    // One-hot LED decode of the captured value.
    always_comb begin
        w_led = '0;
        for (int unsigned i = 0; i < LEDS; i++)
            w_led[i] = bus.rd_en && (r_rd_val == WIDTH'(i));
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.err_cnt = r_err_cnt;
    assign bus.rd_val  = r_rd_val;
    assign bus.led     = w_led;
endmodule
